mips_fetch: RTL and testbench

MIPS_FETCH -- requirements
Module: mips_fetch

---
 rtl/mips_pkg.sv | 12 +
 rtl/mips_fetch.sv | 94 +++++++++
 tb/tb_mips_fetch.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS instruction fetch stage.
package mips_pkg;

  localparam logic [31:0] MIPS_RESET_VECTOR = 32'hBFC00000;

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    HALT_SLOT = 2'd1,
    HALTED    = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/mips_fetch.sv
// Instruction fetch stage: PC register, one-entry pending redirect, IF/ID
// register and halt sequencing triggered by a redirect to address zero.
module mips_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = MIPS_RESET_VECTOR
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] instr_address,
  input  logic [31:0] instr_readdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  input  logic        id_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        active
);

  // Handshake: the IF/ID register transfers to decode on a cycle where
  // if_valid=1 and id_ready=1; while if_valid=1 and id_ready=0 every
  // fetch-side register holds.

  fetch_state_t state, state_next;
  logic [31:0]  pc;
  logic         pend_valid;
  logic [31:0]  pend_target;

  logic         advance;
  logic         take_redirect;
  logic         redirect_hit;
  logic [31:0]  redirect_pc;
  logic [31:0]  next_pc;

  assign instr_address = pc;
  assign active        = (state != HALTED);

  always_comb begin
    advance       = active && (!if_valid || id_ready);
    take_redirect = redirect_valid && (state == RUN);
    redirect_hit  = pend_valid || take_redirect;
    redirect_pc   = pend_valid ? pend_target : redirect_target;
    next_pc       = redirect_hit ? redirect_pc : pc + 32'd4;
  end

  // A halt redirect that arrives with an advance has its delay slot loaded by
  // that same advance, so it goes straight to HALTED. One arriving during a
  // stall parks in HALT_SLOT until the slot fetch completes.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (advance && redirect_hit && (redirect_pc == 32'h0))
          state_next = HALTED;
        else if (!advance && take_redirect && (redirect_target == 32'h0))
          state_next = HALT_SLOT;
      end
      HALT_SLOT: if (advance) state_next = HALTED;
      HALTED:    state_next = HALTED;
      default:   state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_VECTOR;
      if_valid    <= 1'b0;
      if_instr    <= 32'h0;
      if_pc       <= 32'h0;
      pend_valid  <= 1'b0;
      pend_target <= 32'h0;
    end else if (advance) begin
      if_instr   <= instr_readdata;
      if_pc      <= pc;
      if_valid   <= 1'b1;
      pc         <= next_pc;
      pend_valid <= 1'b0;
    end else begin
      // Without an advance, id_ready=1 only occurs once halted: drain the slot.
      if (id_ready) if_valid <= 1'b0;
      if (take_redirect) begin
        pend_valid  <= 1'b1;
        pend_target <= redirect_target;
      end
    end
  end

endmodule

// File: tb/tb_mips_fetch.sv
// Self-checking bench for mips_fetch: directed scenarios followed by random
// traffic, all compared against a behavioural model of the fetch rules.
module tb_mips_fetch;

  logic        clk;
  logic        reset;
  logic [31:0] instr_address;
  logic [31:0] instr_readdata;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        active;

  int checks   = 0;
  int failures = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  mips_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .instr_address   (instr_address),
    .instr_readdata  (instr_readdata),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .if_valid        (if_valid),
    .id_ready        (id_ready),
    .if_instr        (if_instr),
    .if_pc           (if_pc),
    .active          (active)
  );

  // Instruction memory: the word stored at an address is that address / 4.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a / 4;
  endfunction
  assign instr_readdata = mem_word(instr_address);

  // ---------------- reference model ----------------
  // phase: 0 running, 1 halt requested but delay slot not yet fetched, 2 halted
  logic [31:0] m_pc;
  logic        m_pend_v;
  logic [31:0] m_pend_t;
  int          m_phase;
  logic        m_ifv;
  logic [31:0] m_ifi;
  logic [31:0] m_ifp;
  logic [31:0] exp_q[$];  // addresses expected to be delivered to decode

  task automatic model_reset();
    m_pc     = 32'hBFC00000;
    m_pend_v = 1'b0;
    m_pend_t = 32'h0;
    m_phase  = 0;
    m_ifv    = 1'b0;
    m_ifi    = 32'h0;
    m_ifp    = 32'h0;
    exp_q.delete();
  endtask

  // ---------------- scoreboard ----------------
  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check32({tag, ":instr_address"}, instr_address, m_pc);
    check32({tag, ":if_valid"}, {31'h0, if_valid}, {31'h0, m_ifv});
    check32({tag, ":active"}, {31'h0, active}, {31'h0, (m_phase != 2)});
    if (m_ifv) begin
      check32({tag, ":if_instr"}, if_instr, m_ifi);
      check32({tag, ":if_pc"}, if_pc, m_ifp);
    end
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drives inputs, lets one rising edge pass, then
  // checks the DUT against the model at the next falling edge.
  task automatic step(input logic rv, input logic [31:0] rt, input logic rdy);
    logic        adv;
    logic        have_t;
    logic [31:0] tgt;
    redirect_valid  = rv;
    redirect_target = rt;
    id_ready        = rdy;
    adv = (m_phase != 2) && (!m_ifv || rdy);
    if (m_ifv && rdy) begin
      check32("accept_order", m_ifp, exp_q.pop_front());
    end
    @(posedge clk);
    if (adv) begin
      have_t = m_pend_v || (rv && m_phase == 0);
      tgt    = m_pend_v ? m_pend_t : rt;
      m_ifi  = mem_word(m_pc);
      m_ifp  = m_pc;
      m_ifv  = 1'b1;
      exp_q.push_back(m_pc);
      if (m_phase == 1 || (have_t && tgt == 32'h0)) m_phase = 2;
      m_pc     = have_t ? tgt : m_pc + 32'd4;
      m_pend_v = 1'b0;
    end else begin
      if (m_ifv && rdy) m_ifv = 1'b0;
      if (rv && m_phase == 0) begin
        m_pend_v = 1'b1;
        m_pend_t = rt;
        if (rt == 32'h0) m_phase = 1;
      end
    end
    @(negedge clk);
    check_all("step");
  endtask

  // Asserts reset mid-cycle, checks the asynchronous effect, releases it on
  // the following falling edge.
  task automatic apply_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int halted_cycles;
    logic        rv;
    logic [31:0] rt;
    reset           = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    id_ready        = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check32("reset_addr", instr_address, 32'hBFC00000);
    check32("reset_if_valid", {31'h0, if_valid}, 32'h0);
    check32("reset_if_instr", if_instr, 32'h0);
    check32("reset_if_pc", if_pc, 32'h0);
    check32("reset_active", {31'h0, active}, 32'h1);
    reset = 1'b0;

    // Sequential fetch, one per cycle, if_pc trailing the address by a cycle.
    step(1'b0, 32'h0, 1'b1);
    check32("seq_addr1", instr_address, 32'hBFC00004);
    check32("seq_if_pc0", if_pc, 32'hBFC00000);
    check32("seq_if_instr0", if_instr, 32'h2FF00000);
    step(1'b0, 32'h0, 1'b1);
    check32("seq_addr2", instr_address, 32'hBFC00008);
    check32("seq_if_pc1", if_pc, 32'hBFC00004);

    // Three stalled cycles hold everything.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 32'h0, 1'b0);
      check32("stall_if_pc", if_pc, 32'hBFC00004);
      check32("stall_addr", instr_address, 32'hBFC00008);
    end
    step(1'b0, 32'h0, 1'b1);
    check32("resume_if_pc", if_pc, 32'hBFC00008);

    // Redirect at pc=BFC0000C: delay slot C, then the target.
    check32("pre_redirect_addr", instr_address, 32'hBFC0000C);
    step(1'b1, 32'hBFC00040, 1'b1);
    check32("redirect_slot_pc", if_pc, 32'hBFC0000C);
    check32("redirect_addr", instr_address, 32'hBFC00040);

    // Redirect during a stall lands once decode releases.
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'hBFC00060, 1'b0);
    step(1'b1, 32'hBFC00080, 1'b0);
    check32("stall_redirect_hold", instr_address, 32'hBFC00044);
    step(1'b0, 32'h0, 1'b1);
    check32("pending_addr", instr_address, 32'hBFC00080);
    check32("pending_slot_pc", if_pc, 32'hBFC00044);

    // Halt: redirect to zero at pc=BFC00010.
    apply_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1);
    check32("halt_pre_addr", instr_address, 32'hBFC00010);
    step(1'b1, 32'h0, 1'b1);
    check32("halt_slot_pc", if_pc, 32'hBFC00010);
    check32("halt_active", {31'h0, active}, 32'h0);
    step(1'b1, 32'hBFC00100, 1'b1);
    check32("halt_drain", {31'h0, if_valid}, 32'h0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'hBFC00200, 1'($urandom_range(0, 1)));

    // Halt requested during a stall, then reset while the slot is pending.
    apply_reset();
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0, 1'b0);
    check32("halt_slot_active", {31'h0, active}, 32'h1);
    apply_reset();
    step(1'b0, 32'h0, 1'b1);
    check32("restart_if_pc", if_pc, 32'hBFC00000);

    // Random traffic.
    halted_cycles = 0;
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 3) == 0);
      rt = ($urandom_range(0, 24) == 0) ? 32'h0
                                         : (32'hBFC00000 | (32'($urandom_range(0, 255)) << 2));
      step(rv, rt, 1'($urandom_range(0, 3) != 0));
      if (m_phase == 2) halted_cycles++;
      if (halted_cycles > 4) begin
        halted_cycles = 0;
        apply_reset();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
